// File: rtl/speed2phase_pkg.sv
// Shared formats and constants for the speed/phase conversion pair.
// Speed is signed 6Q10 and phase is signed 9Q10; the estimator uses SCALE, this block uses INV_SCALE.
package speed2phase_pkg;

    localparam int PHASE_W   = 19;
    localparam int SPEED_W   = 16;
    localparam int FRAC_W    = 10;
    localparam int PROD_W    = 32;

    localparam int SCALE     = 20450;
    localparam int INV_SCALE = 26253;
    localparam int INV_SHIFT = 12;
    localparam int EST_SHIFT = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/speed2phase_scale.sv
// Registered signed multiply by a fixed unsigned coefficient, followed by a floor shift/slice.
// Output is valid one clock after the input strobe.
module speed2phase_scale
    import speed2phase_pkg::*;
#(
    parameter int                DATA_W = SPEED_W,
    parameter int                COEF_W = 16,
    parameter logic [COEF_W-1:0] COEF   = COEF_W'(INV_SCALE),
    parameter int                SHIFT  = INV_SHIFT,
    parameter int                OUT_W  = PHASE_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     vld_p0,
    input  logic signed [DATA_W-1:0] data_p0,
    output logic                     vld_p1,
    output logic signed [OUT_W-1:0]  data_p1
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0] data_ext_p0;
    logic signed [PW-1:0] coef_ext_p0;
    logic signed [PW-1:0] prod_p0;
    logic signed [PW-1:0] prod_p1;

    // Dropping low bits of a two's-complement word is a floor, so negative inputs round down.
    function automatic logic signed [OUT_W-1:0] floor_shift(input logic signed [PW-1:0] p);
        return OUT_W'(p >>> SHIFT);
    endfunction

    // The coefficient is zero-extended so it always acts as a positive gain.
    assign data_ext_p0 = {{(PW-DATA_W){data_p0[DATA_W-1]}}, data_p0};
    assign coef_ext_p0 = {{(PW-COEF_W){1'b0}}, COEF};
    assign prod_p0     = data_ext_p0 * coef_ext_p0;

    // p0 -> p1: product register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            prod_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                prod_p1 <= prod_p0;
            end
        end
    end

    assign data_p1 = floor_shift(prod_p1);

endmodule

// File: rtl/speed2phase.sv
// Speed-to-phase stimulus source: converts a 6Q10 speed word to a 9Q10 phase and
// presents it on 2**N + 1 consecutive sample strobes, then returns to IDLE.
module speed2phase
    import speed2phase_pkg::*;
#(
    parameter int N         = 6,
    parameter int INV_SCALE = speed2phase_pkg::INV_SCALE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic signed [SPEED_W-1:0] speed,
    input  logic                      speed_valid,
    output logic                      speed_ready,
    input  logic                      sample,
    output logic signed [PHASE_W-1:0] phase,
    output logic                      phase_valid,
    output logic                      block_done
);

    localparam int               CNT_W     = N + 2;
    localparam logic [CNT_W-1:0] BLOCK_LEN = CNT_W'((1 << N) + 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_W-1:0]            cnt;
    logic signed [SPEED_W-1:0]   speed_p0;
    logic                        vld_p0;
    logic                        vld_p1;
    logic signed [PHASE_W-1:0]   phase_p1;
    logic                        xfer;
    logic                        emit_strobe;
    logic                        last_strobe;

    assign speed_ready = (state == ST_IDLE);
    assign xfer        = speed_valid && speed_ready;
    assign emit_strobe = (state == ST_EMIT) && sample;
    assign last_strobe = emit_strobe && (cnt == CNT_W'(1));
    assign vld_p0      = (state == ST_CALC);

    speed2phase_scale #(
        .DATA_W (SPEED_W),
        .COEF_W (16),
        .COEF   (16'(INV_SCALE)),
        .SHIFT  (INV_SHIFT),
        .OUT_W  (PHASE_W)
    ) u_scale (
        .clock   (clock),
        .reset   (reset),
        .vld_p0  (vld_p0),
        .data_p0 (speed_p0),
        .vld_p1  (vld_p1),
        .data_p1 (phase_p1)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer) state_nxt = ST_CALC;
            ST_CALC: state_nxt = ST_EMIT;
            ST_EMIT: if (last_strobe) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes outside EMIT never reach the counter, so IDLE and CALC cannot shorten a block.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            speed_p0    <= '0;
            cnt         <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            block_done  <= 1'b0;
        end else begin
            phase_valid <= emit_strobe;
            block_done  <= last_strobe;
            if (xfer) begin
                speed_p0 <= speed;
            end
            if (state == ST_CALC) begin
                cnt <= BLOCK_LEN;
            end else if (emit_strobe) begin
                cnt <= cnt - 1'b1;
            end
            // p1 -> output: phase stays put in IDLE so the downstream sees a continuous signal
            if (vld_p1) begin
                phase <= phase_p1;
            end
        end
    end

endmodule

// File: tb/tb_speed2phase.sv
// Scoreboard bench for speed2phase: the driver queues expected phase samples, the monitor
// pops one on every phase_valid, and a small averaging estimator model closes the loop.
module tb_speed2phase;
    import speed2phase_pkg::*;

    localparam int N   = 6;
    localparam int BLK = (1 << N) + 1;

    logic                      clock = 1'b0;
    logic                      reset;
    logic signed [SPEED_W-1:0] speed;
    logic                      speed_valid;
    logic                      speed_ready;
    logic                      sample;
    logic signed [PHASE_W-1:0] phase;
    logic                      phase_valid;
    logic                      block_done;

    always #5 clock = ~clock;

    speed2phase #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .speed       (speed),
        .speed_valid (speed_valid),
        .speed_ready (speed_ready),
        .sample      (sample),
        .phase       (phase),
        .phase_valid (phase_valid),
        .block_done  (block_done)
    );

    typedef struct {
        int phase;
        bit done;
        int gap;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec   = 0;
    int     n_miss  = 0;
    int     cyc     = 0;
    int     last_vld_cyc = -1000;
    longint est_acc = 0;
    int     est_n   = 0;
    int     est_last = 0;
    int     est_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic report_fail(input string name, input longint act, input longint req);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compare every emitted sample against the scoreboard and feed the estimator model.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                est_acc = 0;
                est_n   = 0;
            end else if (phase_valid) begin
                if (exp_q.size() == 0) begin
                    report_fail("unexpected_phase_valid", phase_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("phase", phase, e.phase);
                    check("block_done", block_done, e.done);
                    if (e.gap > 0) check("valid_spacing", cyc - last_vld_cyc, e.gap);
                end
                last_vld_cyc = cyc;
                if (est_n < (1 << N)) begin
                    est_acc += phase;
                    est_n++;
                end else begin
                    est_last = int'(((est_acc >>> N) * SCALE) >>> EST_SHIFT);
                    est_cnt++;
                    est_acc = 0;
                    est_n   = 0;
                end
            end else if (block_done) begin
                report_fail("block_done_without_valid", block_done, 0);
            end
        end
    end

    task automatic transfer(input logic signed [15:0] s, input int exp_phase, input int old_phase);
        @(posedge clock); #1;
        speed       = s;
        speed_valid = 1'b1;
        check("ready_before_xfer", speed_ready, 1);
        @(posedge clock); #1;
        speed_valid = 1'b0;
        speed       = 16'sh5A5A;
        check("ready_after_xfer", speed_ready, 0);
        @(posedge clock); #1;
        check("phase_hold_calc", phase, old_phase);
        @(posedge clock); #1;
        check("phase_update", phase, exp_phase);
    endtask

    task automatic push_block(input int exp_phase, input int nstrobe, input int spacing,
                              input int first_gap, input bit full);
        exp_t e;
        for (int i = 0; i < nstrobe; i++) begin
            e.phase = exp_phase;
            e.done  = full && (i == nstrobe - 1);
            e.gap   = (i == 0) ? first_gap : spacing;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_block(input int exp_phase, input int nstrobe, input int spacing, input bit full);
        push_block(exp_phase, nstrobe, spacing, 0, full);
        for (int i = 0; i < nstrobe; i++) begin
            sample = 1'b1;
            @(posedge clock); #1;
            sample = 1'b0;
            if (i != nstrobe - 1) begin
                repeat (spacing - 1) begin
                    @(posedge clock); #1;
                end
            end
        end
        if (full) check("ready_after_block", speed_ready, 1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int k;
        int est_before;
        reset       = 1'b0;
        speed       = '0;
        speed_valid = 1'b0;
        sample      = 1'b0;

        // Reset values and an idle stretch with strobes but no speed word
        #12;
        check("rst_speed_ready", speed_ready, 1);
        check("rst_phase", phase, 0);
        check("rst_phase_valid", phase_valid, 0);
        check("rst_block_done", block_done, 0);
        @(posedge clock); #3;
        reset = 1'b1;
        repeat (20) begin
            @(posedge clock); #1;
            sample = ~sample;
        end
        sample = 1'b0;
        check("idle_speed_ready", speed_ready, 1);
        check("idle_phase", phase, 0);
        check("idle_phase_valid", phase_valid, 0);
        check("idle_block_done", block_done, 0);

        // 1.0 with a strobe every 4 clocks
        transfer(16'sd1024, 6563, 0);
        run_block(6563, BLK, 4, 1);
        drain("drain_1024");

        // Negative floor, zero and full-scale positive
        transfer(-16'sd1024, -6564, 6563);
        run_block(-6564, BLK, 2, 1);
        drain("drain_m1024");
        transfer(16'sd0, 0, -6564);
        run_block(0, BLK, 2, 1);
        drain("drain_0");
        transfer(16'sd32767, 210017, 0);
        run_block(210017, BLK, 2, 1);
        drain("drain_32767");

        // speed_valid held high, sample every cycle: two blocks 3 pulses apart
        push_block(3281, BLK, 1, 0, 1);
        push_block(-3282, BLK, 1, 3, 1);
        @(posedge clock); #1;
        speed       = 16'sd512;
        speed_valid = 1'b1;
        sample      = 1'b1;
        @(posedge clock); #1;
        speed = -16'sd512;
        k = 0;
        while (!speed_ready && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        check("b2b_first_block_end", speed_ready, 1);
        @(posedge clock); #1;
        speed_valid = 1'b0;
        speed       = '0;
        k = 0;
        while (!speed_ready && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        check("b2b_second_block_end", speed_ready, 1);
        sample = 1'b0;
        drain("drain_b2b");

        // Asynchronous reset after the 30th strobe discards the block
        transfer(16'sd1024, 6563, -3282);
        run_block(6563, 30, 2, 0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_speed_ready", speed_ready, 1);
        check("async_rst_phase", phase, 0);
        check("async_rst_phase_valid", phase_valid, 0);
        check("async_rst_block_done", block_done, 0);
        sample = 1'b1;
        repeat (3) @(posedge clock);
        #3;
        sample = 1'b0;
        reset  = 1'b1;
        check("reset_flush", exp_q.size(), 0);
        transfer(16'sd1024, 6563, 0);
        run_block(6563, BLK, 2, 1);
        drain("drain_after_reset");

        // Loop-back through the averaging estimator model
        est_before = est_cnt;
        transfer(16'sd2048, 13126, 6563);
        run_block(13126, BLK, 2, 1);
        drain("drain_2048");
        check("est_latched", est_cnt, est_before + 1);
        check("est_speed_within_1lsb", (est_last >= 2047 && est_last <= 2049), 1);

        repeat (5) @(posedge clock);
        #1;
        check("queue_empty_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
